cfg_tx: RTL



---
 rtl/cfg_tx_if.sv | 28 ++
 rtl/cfg_tx.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/cfg_tx_if.sv
// Host-to-transmitter word stream: valid/ready handshake carrying one context
// word plus the per-frame segment count and final-frame flag.
interface cfg_tx_if #(
   parameter int W_MAX = 64,
   parameter int SW    = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [W_MAX-1:0] in_data;
   logic [SW-1:0]    in_segs;
   logic             in_last;

   modport master (
      output in_valid,
      output in_data,
      output in_segs,
      output in_last,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_segs,
      input  in_last,
      output in_ready
   );
endinterface

// File: rtl/cfg_tx.sv
// Configuration frame transmitter: buffers M context words, then emits a start
// token followed by all segments in slice-major, context-minor order onto the
// config chain. Frames repeat until one flagged as last has been sent.
module cfg_tx #(
   parameter int M     = 8,
   parameter int W_MAX = 64,
   parameter int CFG_W = 4,
   parameter int S_MAX = (W_MAX + CFG_W - 1) / CFG_W,
   parameter int SW    = $clog2(S_MAX + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   cfg_tx_if.slave          in_if,
   output logic [CFG_W-1:0] cfg_o,
   output logic             frm_done_o,
   output logic             cfg_done_o
);

   localparam int CW    = (M > 1) ? $clog2(M) : 1;
   localparam int EXT_W = S_MAX * CFG_W;

   typedef enum logic [1:0] {
      S_FILL  = 2'd0,
      S_TOKEN = 2'd1,
      S_SEND  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Pick one CFG_W slice of a word; slices past W_MAX read as zero.
   function automatic logic [CFG_W-1:0] get_seg(input logic [W_MAX-1:0] word,
                                                input logic [SW-1:0]    slc);
      logic [EXT_W-1:0] ext;
      ext = EXT_W'(word);
      ext = ext >> (32'(slc) * CFG_W);
      return ext[CFG_W-1:0];
   endfunction

   // Map the host's segment count onto 1..S_MAX (0 and out-of-range mean S_MAX).
   function automatic logic [SW-1:0] norm_segs(input logic [SW-1:0] segs);
      if ((segs == {SW{1'b0}}) || (segs > SW'(S_MAX))) begin
         return SW'(S_MAX);
      end else begin
         return segs;
      end
   endfunction

   state_t           state_q;
   logic [CW-1:0]    wc_q;
   logic [CW-1:0]    ctx_q;
   logic [SW-1:0]    slc_q;
   logic [SW-1:0]    segs_q;
   logic             last_q;
   logic [CFG_W-1:0] cfg_q;
   logic             frm_q;
   logic             done_q;
   logic             rdy_q;
   logic [W_MAX-1:0] buf_q [0:M-1];

   logic             acc_d;
   logic [CFG_W-1:0] seg_d;
   logic             fin_d;

   // Handshake decode and the segment addressed by the context/slice counters.
   always_comb begin
      acc_d = in_if.in_valid && rdy_q;
      seg_d = get_seg(buf_q[ctx_q], slc_q);
      if ((ctx_q == CW'(M - 1)) && (slc_q == (segs_q - SW'(1)))) begin
         fin_d = 1'b1;
      end else begin
         fin_d = 1'b0;
      end
   end

   // Frame buffer: written only on accepted words, never reset.
   always_ff @(posedge clk) begin
      if (acc_d) begin
         buf_q[wc_q] <= in_if.in_data;
      end
   end

   // Main FSM with registered chain output, ready and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FILL;
         wc_q    <= {CW{1'b0}};
         ctx_q   <= {CW{1'b0}};
         slc_q   <= {SW{1'b0}};
         segs_q  <= SW'(S_MAX);
         last_q  <= 1'b0;
         cfg_q   <= {CFG_W{1'b0}};
         frm_q   <= 1'b0;
         done_q  <= 1'b0;
         rdy_q   <= 1'b1;
      end else begin
         case (state_q)
            S_FILL: begin
               cfg_q <= {CFG_W{1'b0}};
               frm_q <= 1'b0;
               if (acc_d) begin
                  if (wc_q == {CW{1'b0}}) begin
                     segs_q <= norm_segs(in_if.in_segs);
                     last_q <= in_if.in_last;
                  end
                  if (wc_q == CW'(M - 1)) begin
                     // Frame complete: token goes out on the very next cycle.
                     wc_q    <= {CW{1'b0}};
                     ctx_q   <= {CW{1'b0}};
                     slc_q   <= {SW{1'b0}};
                     cfg_q   <= CFG_W'(1);
                     rdy_q   <= 1'b0;
                     state_q <= S_TOKEN;
                  end else begin
                     wc_q <= wc_q + CW'(1);
                  end
               end
            end
            S_TOKEN, S_SEND: begin
               if ((state_q == S_SEND) && frm_q) begin
                  // Last segment is on the chain now; close the frame.
                  cfg_q <= {CFG_W{1'b0}};
                  frm_q <= 1'b0;
                  ctx_q <= {CW{1'b0}};
                  slc_q <= {SW{1'b0}};
                  if (last_q) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     rdy_q   <= 1'b1;
                     state_q <= S_FILL;
                  end
               end else begin
                  cfg_q   <= seg_d;
                  frm_q   <= fin_d;
                  state_q <= S_SEND;
                  if (ctx_q == CW'(M - 1)) begin
                     ctx_q <= {CW{1'b0}};
                     slc_q <= slc_q + SW'(1);
                  end else begin
                     ctx_q <= ctx_q + CW'(1);
                  end
               end
            end
            S_DONE: begin
               cfg_q  <= {CFG_W{1'b0}};
               frm_q  <= 1'b0;
               rdy_q  <= 1'b0;
               done_q <= 1'b1;
            end
            default: begin
               state_q <= S_FILL;
               cfg_q   <= {CFG_W{1'b0}};
               frm_q   <= 1'b0;
               rdy_q   <= 1'b1;
            end
         endcase
      end
   end

   assign in_if.in_ready = rdy_q;
   assign cfg_o          = cfg_q;
   assign frm_done_o     = frm_q;
   assign cfg_done_o     = done_q;

endmodule
